adc_decimator: RTL and testbench



---
 rtl/adc_decim_pkg.sv | 16 +
 rtl/adc_decim_outreg.sv | 49 ++++
 rtl/adc_decimator.sv | 165 ++++++++++++++++
 tb/tb_adc_decimator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_decim_pkg.sv
// Shared types and helpers for the adc_decimator block.
package adc_decim_pkg;

    typedef enum logic {
        IDLE,
        ACCUM
    } decim_state_e;

    localparam int unsigned DECIM_DATA_WIDTH = 32;
    localparam int unsigned DECIM_MAX_LOG2   = 8;

    function automatic int unsigned clamp_log2(input int unsigned req, input int unsigned max_log2);
        return (req > max_log2) ? max_log2 : req;
    endfunction

endpackage

// File: rtl/adc_decim_outreg.sv
// Single-entry AXI-Stream output register; flags a drop when a new word
// arrives while the held word is neither empty nor draining.
module adc_decim_outreg #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    input  logic                  m_tready,
    output logic                  drop
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  drain;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        drain   = valid_q && m_tready;
        drop    = 1'b0;
        if (in_valid && (!valid_q || drain)) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else begin
            if (drain) begin
                valid_d = 1'b0;
            end
            drop = in_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign m_tvalid = valid_q;
    assign m_tdata  = data_q;

endmodule

// File: rtl/adc_decimator.sv
// Block-averaging power-of-two decimator for the adc_manager sample stream.
// Optional packet framing on m_axis_tlast when ADC_DECIM_TLAST_EN is defined.
module adc_decimator
    import adc_decim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DECIM_DATA_WIDTH,
    parameter int unsigned MAX_LOG2   = DECIM_MAX_LOG2,
    parameter int unsigned LOG2_W     = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PACKET_LEN = 256
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [LOG2_W-1:0]     ratio_log2,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [CNT_W-1:0]      overflow_count,
    output logic                  active
);

    localparam int unsigned ACC_W = DATA_WIDTH + MAX_LOG2;

    decim_state_e             state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [MAX_LOG2-1:0]      cnt_q, cnt_d;
    logic [LOG2_W-1:0]        ratio_q, ratio_d;
    logic                     tready_q;
    logic [CNT_W-1:0]         ovf_q, ovf_d;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  sum;
    logic [LOG2_W-1:0]        ratio_clamped;
    logic                     in_hs;
    logic                     res_valid;
    logic [DATA_WIDTH-1:0]    res_data;
    logic                     drop;

    assign in_hs         = s_axis_tvalid && tready_q;
    assign sample_ext    = {{MAX_LOG2{s_axis_tdata[DATA_WIDTH-1]}}, s_axis_tdata};
    assign sum           = acc_q + sample_ext;
    assign res_data      = DATA_WIDTH'(sum >>> ratio_q);
    assign ratio_clamped = LOG2_W'(clamp_log2(32'(ratio_log2), MAX_LOG2));

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ratio_d   = ratio_q;
        res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (enable) begin
                    state_d = ACCUM;
                    ratio_d = ratio_clamped;
                end
            end
            ACCUM: begin
                // Disable wins over a completing handshake in the same cycle.
                if (!enable) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (in_hs) begin
                    if (32'(cnt_q) == (32'd1 << ratio_q) - 32'd1) begin
                        res_valid = 1'b1;
                        acc_d     = '0;
                        cnt_d     = '0;
                        ratio_d   = ratio_clamped;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop && (ovf_q != '1)) begin
            ovf_d = ovf_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            ratio_q  <= '0;
            tready_q <= 1'b0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ratio_q  <= ratio_d;
            tready_q <= 1'b1;
            ovf_q    <= ovf_d;
        end
    end

    adc_decim_outreg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_outreg (
        .clk     (clk),
        .resetn  (resetn),
        .in_valid(res_valid),
        .in_data (res_data),
        .m_tvalid(m_axis_tvalid),
        .m_tdata (m_axis_tdata),
        .m_tready(m_axis_tready),
        .drop    (drop)
    );

    assign s_axis_tready  = tready_q;
    assign overflow_count = ovf_q;
    assign active         = (state_q == ACCUM);

`ifdef ADC_DECIM_TLAST_EN
    localparam int unsigned WCNT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

    logic [WCNT_W-1:0] word_q, word_d;
    logic              restart_q, restart_d;
    logic              word_last;

    assign word_last = (32'(word_q) == PACKET_LEN - 1);

    // A disable only restarts the packet once any pending word has gone out.
    always_comb begin
        word_d    = word_q;
        restart_d = restart_q || !enable;
        if (m_axis_tvalid && m_axis_tready) begin
            word_d = word_last ? '0 : word_q + 1'b1;
        end
        if (restart_q && !m_axis_tvalid) begin
            word_d    = '0;
            restart_d = !enable;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_q    <= '0;
            restart_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            restart_q <= restart_d;
        end
    end

    assign m_axis_tlast = m_axis_tvalid && word_last;
`else
    assign m_axis_tlast = 1'b0;
`endif

endmodule

// File: tb/tb_adc_decimator.sv
// Directed self-checking bench for adc_decimator (default build, or with
// ADC_DECIM_TLAST_EN defined to exercise packet framing at PACKET_LEN=4).
module tb_adc_decimator;

    logic        clk;
    logic        resetn;
    logic        enable;
    logic [3:0]  ratio_log2;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [15:0] ovf;
    logic        active;

    int unsigned n_cmp;
    int unsigned n_err;

    adc_decimator #(
        .DATA_WIDTH(32),
        .MAX_LOG2  (8),
        .LOG2_W    (4),
        .CNT_W     (16),
        .PACKET_LEN(4)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .ratio_log2    (ratio_log2),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .overflow_count(ovf),
        .active        (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [31:0] d);
        s_tdata  = d;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic restart(input logic [3:0] r);
        enable = 1'b0;
        @(posedge clk);
        #1;
        ratio_log2 = r;
        enable     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b expected 0", m_tvalid); end
        n_cmp++; if (m_tdata !== 32'h0) begin n_err++; $display("FAIL rst_tdata: got %h expected 0", m_tdata); end
        n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b expected 0", s_tready); end
        n_cmp++; if (ovf !== 16'h0) begin n_err++; $display("FAIL rst_ovf: got %0d expected 0", ovf); end
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL rst_active: got %b expected 0", active); end
        n_cmp++; if (m_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b expected 0", m_tlast); end
        resetn = 1'b1;
        #1;
        n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rel_tready_early: got %b expected 0", s_tready); end
        @(posedge clk);
        #1;
        n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL rel_tready: got %b expected 1", s_tready); end
    endtask

    task automatic test_avg4;
        logic [31:0] vals [4];
        vals = '{32'd4, 32'd8, 32'd12, 32'd16};
        m_tready = 1'b0;
        restart(4'd2);
        n_cmp++; if (active !== 1'b1) begin n_err++; $display("FAIL avg_active_start: got %b expected 1", active); end
        for (int i = 0; i < 3; i++) begin
            send(vals[i]);
            n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL avg_early_valid[%0d]: got %b expected 0", i, m_tvalid); end
            n_cmp++; if (active !== 1'b1) begin n_err++; $display("FAIL avg_active[%0d]: got %b expected 1", i, active); end
        end
        send(vals[3]);
        n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL avg_valid: got %b expected 1", m_tvalid); end
        n_cmp++; if (m_tdata !== 32'd10) begin n_err++; $display("FAIL avg_data: got %h expected %h", m_tdata, 32'd10); end
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL avg_drain: got %b expected 0", m_tvalid); end
    endtask

    task automatic test_passthrough;
        m_tready = 1'b1;
        restart(4'd0);
        send(32'h8BADF00D);
        n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL pt_valid0: got %b expected 1", m_tvalid); end
        n_cmp++; if (m_tdata !== 32'h8BADF00D) begin n_err++; $display("FAIL pt_data0: got %h expected 8badf00d", m_tdata); end
        send(32'h0023FF42);
        n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL pt_valid1: got %b expected 1", m_tvalid); end
        n_cmp++; if (m_tdata !== 32'h0023FF42) begin n_err++; $display("FAIL pt_data1: got %h expected 0023ff42", m_tdata); end
        n_cmp++; if (ovf !== 16'd0) begin n_err++; $display("FAIL pt_ovf: got %0d expected 0", ovf); end
        @(posedge clk);
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL pt_drain: got %b expected 0", m_tvalid); end
    endtask

    task automatic test_floor;
        m_tready = 1'b1;
        restart(4'd1);
        send(32'hFFFFFFFF);
        send(32'hFFFFFFFE);
        n_cmp++; if (m_tdata !== 32'hFFFFFFFE || m_tvalid !== 1'b1) begin n_err++; $display("FAIL floor_m1m2: got %h/%b expected fffffffe/1", m_tdata, m_tvalid); end
        send(32'hFFFFFFFF);
        send(32'hFFFFFFFF);
        n_cmp++; if (m_tdata !== 32'hFFFFFFFF || m_tvalid !== 1'b1) begin n_err++; $display("FAIL floor_m1m1: got %h/%b expected ffffffff/1", m_tdata, m_tvalid); end
        send(32'd3);
        send(32'd4);
        n_cmp++; if (m_tdata !== 32'd3 || m_tvalid !== 1'b1) begin n_err++; $display("FAIL floor_3_4: got %h/%b expected 00000003/1", m_tdata, m_tvalid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow;
        m_tready = 1'b1;
        restart(4'd0);
        m_tready = 1'b0;
        send(32'h11111111);
        send(32'h22222222);
        send(32'h33333333);
        n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b expected 1", m_tvalid); end
        n_cmp++; if (m_tdata !== 32'h11111111) begin n_err++; $display("FAIL ovf_hold: got %h expected 11111111", m_tdata); end
        n_cmp++; if (ovf !== 16'd2) begin n_err++; $display("FAIL ovf_count: got %0d expected 2", ovf); end
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL ovf_single: got %b expected 0", m_tvalid); end
        n_cmp++; if (ovf !== 16'd2) begin n_err++; $display("FAIL ovf_count_kept: got %0d expected 2", ovf); end
    endtask

    task automatic test_ratio_change_disable;
        m_tready = 1'b1;
        restart(4'd1);
        send(32'd10);
        ratio_log2 = 4'd3;
        send(32'd20);
        n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== 32'd15) begin n_err++; $display("FAIL rc_old_ratio: got %h/%b expected 0000000f/1", m_tdata, m_tvalid); end
        send(32'd1);
        send(32'd2);
        send(32'd3);
        enable = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL rc_disable_active: got %b expected 0", active); end
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rc_disable_valid: got %b expected 0", m_tvalid); end
        restart(4'd0);
        send(32'd7);
        n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== 32'd7) begin n_err++; $display("FAIL rc_partial_discard: got %h/%b expected 00000007/1", m_tdata, m_tvalid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midblock;
        m_tready = 1'b0;
        restart(4'd2);
        for (int i = 0; i < 4; i++) send(32'd1);
        send(32'd5);
        send(32'd5);
        n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== 32'd1) begin n_err++; $display("FAIL mr_pending: got %h/%b expected 00000001/1", m_tdata, m_tvalid); end
        #2;
        resetn = 1'b0;
        enable = 1'b0;
        #1;
        n_cmp++; if (m_tvalid !== 1'b0 || m_tdata !== 32'h0) begin n_err++; $display("FAIL mr_out_clear: got %h/%b expected 00000000/0", m_tdata, m_tvalid); end
        n_cmp++; if (s_tready !== 1'b0 || active !== 1'b0 || ovf !== 16'd0 || m_tlast !== 1'b0) begin n_err++; $display("FAIL mr_ctrl_clear: got tready=%b active=%b ovf=%0d tlast=%b expected 0/0/0/0", s_tready, active, ovf, m_tlast); end
        @(posedge clk);
        #1;
        resetn   = 1'b1;
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL mr_no_partial: got %b expected 0", m_tvalid); end
        restart(4'd2);
        for (int i = 0; i < 4; i++) send(32'd4);
        n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== 32'd4) begin n_err++; $display("FAIL mr_fresh_block: got %h/%b expected 00000004/1", m_tdata, m_tvalid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_tlast;
        logic exp_last;
        m_tready = 1'b1;
        restart(4'd0);
        for (int i = 0; i < 9; i++) begin
            send(32'(i + 100));
`ifdef ADC_DECIM_TLAST_EN
            exp_last = (i == 3) || (i == 7);
`else
            exp_last = 1'b0;
`endif
            n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== 32'(i + 100)) begin n_err++; $display("FAIL tl_data[%0d]: got %h/%b expected %h/1", i, m_tdata, m_tvalid, 32'(i + 100)); end
            n_cmp++; if (m_tlast !== exp_last) begin n_err++; $display("FAIL tl_last[%0d]: got %b expected %b", i, m_tlast, exp_last); end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        resetn     = 1'b1;
        enable     = 1'b0;
        ratio_log2 = 4'd0;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        m_tready   = 1'b0;
        #2;
        resetn = 1'b0;
        test_reset;
        test_avg4;
        test_passthrough;
        test_floor;
        test_overflow;
        test_ratio_change_disable;
        test_reset_midblock;
        test_tlast;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
